ps2_host_transmitter: RTL and testbench
=======================================

// Module: ps2_host_transmitter
// PURPOSE
//  Host-to-device PS/2 sender; the transmit end of the keyboard link whose received scancodes feed the Spectrum matrix.
//  Sends one command/argument byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard.
//  Drives the open-collector clock/data lines and checks the device ACK.
//  Sits beside the PS/2 receiver on the same pads; busy gates the receiver while a transfer is in flight.
// PARAMETERS
//  INHIBIT_CYCLES  2800    clk cycles the PS/2 clock is held low before the request (100 us at 28 MHz)
//  TIMEOUT_CYCLES  420000  max clk cycles from send accept to ACK completion (15 ms at 28 MHz)
//  FILTER_LEN      8       consecutive equal synced samples required to accept a new ps2clk level
// PORTS
//  clk          in   1  system clock (same clk as the PS/2 receiver)
//  rst_n        in   1  asynchronous reset, active low
//  ps2clk_in    in   1  PS/2 clock pad level
//  ps2data_in   in   1  PS/2 data pad level
//  ps2clk_oe    out  1  1 = pull PS/2 clock pad low, 0 = release (pad pulled up)
//  ps2data_oe   out  1  1 = pull PS/2 data pad low, 0 = release
//  data_in      in   8  byte to send, sampled on the accepted send cycle
//  send         in   1  1-cycle request; accepted only while busy=0
//  busy         out  1  1 from accepted send until done or error is pulsed
//  done         out  1  1-cycle pulse: byte sent and ACK=0 received
//  error        out  1  1-cycle pulse: timeout, or ACK sampled as 1
// BEHAVIOUR
//  Reset (async, rst_n=0): ps2clk_oe=0, ps2data_oe=0, busy=0, done=0, error=0; state=IDLE; counters cleared.
//   Lines release in the same instant reset asserts, including mid-transfer.
//  Input conditioning:
//   - ps2clk_in and ps2data_in pass through 2-FF synchronisers.
//   - Filtered clock changes level only after FILTER_LEN equal samples.
//   - fall = filtered clock 1->0, registered as a 1-cycle strobe.
//  Data path: shift reg {stop=1, parity, data_in[7:0]} loaded on accept. parity = ~^data_in (odd parity).
//  States:
//   IDLE    - send & ~busy: latch data_in, busy<=1, clear timeout counter -> INHIBIT. send while busy is ignored.
//   INHIBIT - ps2clk_oe=1 for INHIBIT_CYCLES, then ps2data_oe=1 (start bit 0) -> RELEASE.
//   RELEASE - next cycle ps2clk_oe=0 (data still low), bit counter=0 -> SHIFT.
//   SHIFT   - on each fall: bit counter 0..7 -> ps2data_oe=~data[n] (LSB first).
//             Counter 8 -> ps2data_oe=~parity. Counter 9 -> ps2data_oe=0 (stop).
//             Counter 10 -> sample synced data as ACK -> WAITIDLE.
//   WAITIDLE- ACK=0: wait filtered clk=1 and synced data=1, then done<=1, busy<=0 -> IDLE.
//             ACK=1: error<=1, busy<=0 -> IDLE at once.
//  Timeout: counter runs in every state except IDLE.
//   Reaching TIMEOUT_CYCLES: both oe<=0, error<=1, busy<=0 -> IDLE. Timeout wins over a simultaneous fall.
//  Data changes only right after a falling edge; the device samples on the rising edge.
//  Falls seen in INHIBIT/RELEASE (own drive or glitch) are ignored.
//  done and error are never high together; each is high for exactly 1 cycle.
//  Counter widths: $clog2(TIMEOUT_CYCLES+1) and $clog2(INHIBIT_CYCLES+1); no wrap reachable.
// TESTING
//  1. Send 0xED with a device model (clk period 80 us) driving ACK=0 -> ps2clk_oe low 2800 cycles.
//     Data line bits 1,0,1,1,0,1,1,1, parity 1, stop 1; one done pulse, busy 1->0.
//  2. Send 0xF4 -> parity bit 0 on the 9th fall; 0x01 -> parity 0; 0x00 -> parity 1; done each time.
//  3. Device never clocks after the request -> error pulse exactly TIMEOUT_CYCLES after accept.
//     Both oe=0, busy=0, no done.
//  4. Device returns ACK=1 on the 11th fall -> error pulse, no done, lines released.
//  5. send pulsed again mid-SHIFT with data_in=0x55 -> ignored; original byte completes unchanged.
//  6. rst_n low during SHIFT -> oe outputs 0 immediately (async); busy=0.
//     The next send transmits a full fresh frame.
//     A 3-cycle glitch on ps2clk_in produces no bit advance.

Source files
------------

// File: rtl/ps2_host_transmitter.sv
// ps2_host_transmitter
//   Sends one byte from the host to a PS/2 device (keyboard). It drives the
//   open-collector clock/data pads, clocks the frame out on the falling edges
//   the device generates, and checks the device ACK bit.
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous reset, active low
//   ps2clk_in   in   PS/2 clock pad level
//   ps2data_in  in   PS/2 data pad level
//   ps2clk_oe   out  1 = pull the PS/2 clock pad low
//   ps2data_oe  out  1 = pull the PS/2 data pad low
//   data_in     in   byte to send, sampled on the accepted send cycle
//   send        in   one-cycle request, accepted only while busy=0
//   busy        out  high from accepted send until done/error
//   done        out  one-cycle pulse: frame sent and ACK=0 received
//   error       out  one-cycle pulse: timeout or ACK sampled as 1
module ps2_host_transmitter #(
  parameter int INHIBIT_CYCLES = 2800,
  parameter int TIMEOUT_CYCLES = 420000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic [7:0] data_in,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RELEASE,
    SHIFT,
    WAITIDLE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: 2-FF synchronisers (bit 0 = clock, bit 1 = data),
  // idle level of both pads is high.
  // ---------------------------------------------------------------------------
  logic [1:0] sync1_reg;
  logic [1:0] sync2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 2'b11;
      sync2_reg <= 2'b11;
    end else begin
      sync1_reg <= {ps2data_in, ps2clk_in};
      sync2_reg <= sync1_reg;
    end
  end

  logic clk_sync;
  logic data_sync;
  assign clk_sync  = sync2_reg[0];
  assign data_sync = sync2_reg[1];

  // Clock glitch filter: the filtered level flips only after FILTER_LEN
  // consecutive synced samples that differ from it; any sample equal to the
  // current filtered level restarts the count. fall_reg strobes for one cycle
  // when the filtered level goes 1 -> 0.
  logic          filt_clk_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          fall_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_clk_reg <= 1'b1;
      filt_cnt_reg <= '0;
      fall_reg     <= 1'b0;
    end else begin
      fall_reg <= 1'b0;
      if (clk_sync == filt_clk_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
        filt_clk_reg <= clk_sync;
        filt_cnt_reg <= '0;
        fall_reg     <= ~clk_sync;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t        state_reg,   state_next;
  logic [9:0]    shift_reg,   shift_next;    // {stop, parity, data[7:0]}
  logic [3:0]    bit_cnt_reg, bit_cnt_next;
  logic [IW-1:0] inh_cnt_reg, inh_cnt_next;
  logic [TW-1:0] to_cnt_reg,  to_cnt_next;
  logic          clk_oe_reg,  clk_oe_next;
  logic          data_oe_reg, data_oe_next;
  logic          busy_reg,    busy_next;
  logic          done_reg,    done_next;
  logic          error_reg,   error_next;
  logic          ack_reg,     ack_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      inh_cnt_reg <= '0;
      to_cnt_reg  <= '0;
      clk_oe_reg  <= 1'b0;
      data_oe_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
      ack_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      inh_cnt_reg <= inh_cnt_next;
      to_cnt_reg  <= to_cnt_next;
      clk_oe_reg  <= clk_oe_next;
      data_oe_reg <= data_oe_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      error_reg   <= error_next;
      ack_reg     <= ack_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    inh_cnt_next = inh_cnt_reg;
    to_cnt_next  = to_cnt_reg;
    clk_oe_next  = clk_oe_reg;
    data_oe_next = data_oe_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    error_next   = 1'b0;
    ack_next     = ack_reg;

    if (state_reg != IDLE) begin
      to_cnt_next = to_cnt_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;
        if (send) begin
          shift_next   = {1'b1, ~^data_in, data_in};
          busy_next    = 1'b1;
          to_cnt_next  = '0;
          inh_cnt_next = '0;
          clk_oe_next  = 1'b1;
          state_next   = INHIBIT;
        end
      end

      INHIBIT: begin
        clk_oe_next = 1'b1;
        if (inh_cnt_reg == IW'(INHIBIT_CYCLES - 1)) begin
          data_oe_next = 1'b1;               // start bit
          state_next   = RELEASE;
        end else begin
          inh_cnt_next = inh_cnt_reg + 1'b1;
        end
      end

      RELEASE: begin
        clk_oe_next  = 1'b0;
        bit_cnt_next = '0;
        state_next   = SHIFT;
      end

      SHIFT: begin
        if (fall_reg) begin
          if (bit_cnt_reg == 4'd10) begin
            ack_next   = data_sync;
            state_next = WAITIDLE;
          end else begin
            // Counts 0..9 cover data, parity and stop; the stop bit is a 1
            // in the shift register, so the line is released for it.
            data_oe_next = ~shift_reg[bit_cnt_reg];
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end

      WAITIDLE: begin
        if (ack_reg) begin
          clk_oe_next  = 1'b0;
          data_oe_next = 1'b0;
          error_next   = 1'b1;
          busy_next    = 1'b0;
          state_next   = IDLE;
        end else if (filt_clk_reg && data_sync) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // The timeout overrides everything else, including a fall in this cycle.
    if (state_reg != IDLE && to_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
      clk_oe_next  = 1'b0;
      data_oe_next = 1'b0;
      done_next    = 1'b0;
      error_next   = 1'b1;
      busy_next    = 1'b0;
      state_next   = IDLE;
    end
  end

  assign ps2clk_oe  = clk_oe_reg;
  assign ps2data_oe = data_oe_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign error      = error_reg;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// tb_ps2_host_transmitter
//   Drives ps2_host_transmitter against a behavioural PS/2 device on
//   wired-AND pads. Expected frame bits are queued when a byte is sent and
//   popped as the device samples the data line on each rising clock edge.
module tb_ps2_host_transmitter;

  localparam int INHIBIT = 40;
  localparam int TMO     = 3000;
  localparam int FILT    = 8;
  localparam int H       = 24;   // device half clock period, in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2clk_in;
  logic       ps2data_in;
  logic       ps2clk_oe;
  logic       ps2data_oe;
  logic [7:0] data_in = 8'h00;
  logic       send = 1'b0;
  logic       busy;
  logic       done;
  logic       error;

  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;

  // open-collector pads with pull-ups
  assign ps2clk_in  = ~ps2clk_oe  & dev_clk;
  assign ps2data_in = ~ps2data_oe & dev_data;

  ps2_host_transmitter #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FILT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2clk_in (ps2clk_in),
    .ps2data_in(ps2data_in),
    .ps2clk_oe (ps2clk_oe),
    .ps2data_oe(ps2data_oe),
    .data_in   (data_in),
    .send      (send),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // running totals, sampled away from the active edge
  int done_total = 0;
  int err_total  = 0;
  int both_total = 0;
  int inh_total  = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_total++;
    if (error === 1'b1) err_total++;
    if (done === 1'b1 && error === 1'b1) both_total++;
    if (ps2clk_oe === 1'b1 && ps2data_oe === 1'b0) inh_total++;
  end

  logic exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic odd_parity(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic do_send(input logic [7:0] b, input bit push);
    if (push) begin
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
      exp_q.push_back(odd_parity(b));
      exp_q.push_back(1'b1);
    end
    @(negedge clk);
    data_in = b;
    send    = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic wait_request(output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (!(ps2clk_in === 1'b1 && ps2data_in === 1'b0 && ps2clk_oe === 1'b0)) begin
      @(negedge clk);
      n++;
      if (n > INHIBIT + 100) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic dev_pulse();
    dev_clk = 1'b0;
    repeat (H) @(negedge clk);
    dev_clk = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  // Device side of one frame: 11 clocks, data sampled on each rising edge,
  // ACK driven low before the 11th fall unless ack_one is set.
  task automatic device_frame(input bit ack_one, input int glitch_at, input int inject_at);
    bit   ok;
    logic obs;
    logic expv;
    wait_request(ok);
    chk("request_seen", {31'b0, ok}, 32'd1);
    if (!ok) begin
      exp_q.delete();
      return;
    end
    obs  = ps2data_in;
    expv = exp_q.pop_front();
    chk("start_bit", {31'b0, obs}, {31'b0, expv});
    repeat (40) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      if (i == 10 && !ack_one) dev_data = 1'b0;
      dev_clk = 1'b0;
      if (i == inject_at) begin
        data_in = 8'h55;
        send    = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (H - 1) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      dev_clk = 1'b1;
      if (i < 10) begin
        obs  = ps2data_in;
        expv = exp_q.pop_front();
        chk($sformatf("frame_bit%0d", i + 1), {31'b0, obs}, {31'b0, expv});
      end
      if (i == glitch_at) begin
        repeat (13) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (H - 16) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_outcome(input int d0, input int e0);
    int n;
    n = 0;
    while (done_total == d0 && err_total == e0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
  endtask

  // Full frame with ACK=0: bits, inhibit length, one done, no error.
  task automatic frame_ok(input logic [7:0] b, input int glitch_at, input int inject_at);
    int d0, e0, i0;
    d0 = done_total;
    e0 = err_total;
    i0 = inh_total;
    do_send(b, 1'b1);
    chk($sformatf("busy_set_%02h", b), {31'b0, busy}, 32'd1);
    device_frame(1'b0, glitch_at, inject_at);
    wait_outcome(d0, e0);
    chk($sformatf("inhibit_len_%02h", b), inh_total - i0, INHIBIT);
    chk($sformatf("done_once_%02h", b), done_total - d0, 32'd1);
    chk($sformatf("no_error_%02h", b), err_total - e0, 32'd0);
    chk($sformatf("busy_clr_%02h", b), {31'b0, busy}, 32'd0);
    chk($sformatf("lines_rel_%02h", b), {30'b0, ps2clk_oe, ps2data_oe}, 32'd0);
    chk($sformatf("queue_empty_%02h", b), exp_q.size(), 32'd0);
    $display("frame %02h: done=%0d error=%0d", b, done_total - d0, err_total - e0);
  endtask

  initial begin
    int  n;
    bit  got;
    bit  ok;
    int  d0, e0;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe",  {31'b0, ps2clk_oe},  32'd0);
    chk("rst_data_oe", {31'b0, ps2data_oe}, 32'd0);
    chk("rst_busy",    {31'b0, busy},       32'd0);
    chk("rst_done",    {31'b0, done},       32'd0);
    chk("rst_error",   {31'b0, error},      32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // normal frames, covering both parity values
    frame_ok(8'hED, -1, -1);
    frame_ok(8'hF4, -1, -1);
    frame_ok(8'h01, -1, -1);
    frame_ok(8'h00, -1, -1);

    // timeout: device never clocks
    d0 = done_total;
    e0 = err_total;
    @(negedge clk);
    data_in = 8'h3C;
    send    = 1'b1;
    @(posedge clk);
    #1 send = 1'b0;
    n   = 0;
    got = 1'b0;
    while (n < TMO + 50) begin
      @(posedge clk);
      #1;
      n++;
      if (error === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("timeout_seen", {31'b0, got}, 32'd1);
    chk("timeout_latency", n, TMO);
    repeat (3) @(negedge clk);
    chk("timeout_lines", {30'b0, ps2clk_oe, ps2data_oe}, 32'd0);
    chk("timeout_busy", {31'b0, busy}, 32'd0);
    chk("timeout_no_done", done_total - d0, 32'd0);
    chk("timeout_one_error", err_total - e0, 32'd1);
    $display("timeout: latency=%0d error=%0d", n, err_total - e0);

    // ACK returned as 1
    d0 = done_total;
    e0 = err_total;
    do_send(8'hFF, 1'b1);
    device_frame(1'b1, -1, -1);
    wait_outcome(d0, e0);
    chk("nack_error", err_total - e0, 32'd1);
    chk("nack_no_done", done_total - d0, 32'd0);
    chk("nack_lines", {30'b0, ps2clk_oe, ps2data_oe}, 32'd0);
    chk("nack_busy", {31'b0, busy}, 32'd0);
    $display("frame ff nack: done=%0d error=%0d", done_total - d0, err_total - e0);

    // send 0x55 mid-SHIFT is ignored; 0xED completes unchanged
    frame_ok(8'hED, -1, 3);

    // async reset during SHIFT
    do_send(8'h00, 1'b0);
    wait_request(ok);
    chk("rst_req_seen", {31'b0, ok}, 32'd1);
    repeat (40) @(negedge clk);
    repeat (3) dev_pulse();
    chk("pre_rst_data_oe", {31'b0, ps2data_oe}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_clk_oe",  {31'b0, ps2clk_oe},  32'd0);
    chk("async_rst_data_oe", {31'b0, ps2data_oe}, 32'd0);
    chk("async_rst_busy",    {31'b0, busy},       32'd0);
    $display("reset mid-shift: oe=%0b%0b busy=%0b", ps2clk_oe, ps2data_oe, busy);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // fresh frame after reset, with a short clock glitch mid-frame
    frame_ok(8'hA5, 4, -1);

    chk("never_done_and_error", both_total, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
